logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 5-bit bitwise logic unit (AND/OR/XOR/NOR over 5-bit operands). Up to four requesters post an opcode and two 5-bit operands. The block grants one requester at a time, latches its operands, computes the result in a registered stage, and returns it with the requester's ID over a valid/ready handshake. It sits between the ALU-control front end and the 5-bit logic datapath, so that one logic unit serves every client.

---
 rtl/logic_unit_arbiter.sv | 138 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin front end for the shared 5-bit logic unit.
// Four requesters post an opcode and two operands. One of them is granted,
// and its operands are latched. The result is computed in a registered stage
// and returned with the owner's ID over a valid/ready handshake.
module logic_unit_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [7:0]  op_i,
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    output logic [3:0]  gnt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_data,
    output logic [1:0]  res_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] op_q;
    logic [4:0] a_q;
    logic [4:0] b_q;
    logic [1:0] id_q;

    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] sel_op;
    logic [4:0] sel_a;
    logic [4:0] sel_b;

    // The 5-bit bitwise function applied in EXEC.
    function automatic logic [4:0] logic_fn(input logic [1:0] op,
                                            input logic [4:0] a,
                                            input logic [4:0] b);
        unique case (op_t'(op))
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Round-robin search, starting just after the last served requester and
    // ending at that requester itself.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every variable assigned here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        win_found = 1'b0;
        win_id    = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Select the winner's opcode and operand slices.
    always_comb begin
        sel_op = op_i[1:0];
        sel_a  = a_i[4:0];
        sel_b  = b_i[4:0];
        unique case (win_id)
            2'd0: begin sel_op = op_i[1:0]; sel_a = a_i[4:0];   sel_b = b_i[4:0];   end
            2'd1: begin sel_op = op_i[3:2]; sel_a = a_i[9:5];   sel_b = b_i[9:5];   end
            2'd2: begin sel_op = op_i[5:4]; sel_a = a_i[14:10]; sel_b = b_i[14:10]; end
            default: begin sel_op = op_i[7:6]; sel_a = a_i[19:15]; sel_b = b_i[19:15]; end
        endcase
    end

    // Sequencer: grant and latch in IDLE, compute in EXEC, hold until accepted in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 2'd3;
            gnt       <= 4'b0000;
            res_valid <= 1'b0;
            res_data  <= 5'b00000;
            res_id    <= 2'd0;
            op_q      <= 2'd0;
            a_q       <= 5'd0;
            b_q       <= 5'd0;
            id_q      <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the values from before the edge.
            gnt <= 4'b0000;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= win_id;
                        gnt   <= 4'b0001 << win_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= logic_fn(op_q, a_q, b_q);
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Priority rotates only when the result is actually taken.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= res_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed vectors with hand-computed expectations.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  op_i;
    logic [19:0] a_i;
    logic [19:0] b_i;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_data;
    logic [1:0]  res_id;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] sweep_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [4:0] sweep_res [4] = '{5'b10000, 5'b11010, 5'b01010, 5'b00101};

    logic_unit_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
        op_i[2*i +: 2] = op;
        a_i[5*i +: 5]  = a;
        b_i[5*i +: 5]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        op_i      = '0;
        a_i       = '0;
        b_i       = '0;
        res_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_gnt", 8'(gnt), 8'h00);
        check("rst_valid", 8'(res_valid), 8'h00);
        check("rst_data", 8'(res_data), 8'h00);
        check("rst_id", 8'(res_id), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2: OR 10100 | 00011 = 10111.
        set_slot(2, 2'b01, 5'b10100, 5'b00011);
        req = 4'b0100;
        step();
        check("single_gnt", 8'(gnt), 8'b0100);
        check("single_busy", 8'(busy), 8'h01);
        req = 4'b0000;
        step();
        check("single_gnt_pulse", 8'(gnt), 8'h00);
        check("single_valid", 8'(res_valid), 8'h01);
        check("single_data", 8'(res_data), 8'b10111);
        check("single_id", 8'(res_id), 8'd2);
        res_ready = 1'b1;
        step();
        check("single_accept_valid", 8'(res_valid), 8'h00);
        check("single_accept_busy", 8'(busy), 8'h00);

        // All four requesting continuously, starting from reset priority.
        do_reset();
        res_ready = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            check("rr_gnt", 8'(gnt), 8'(exp_gnt[g]));
            step();
            check("rr_gap1", 8'(gnt), 8'h00);
            step();
            check("rr_gap2", 8'(gnt), 8'h00);
        end
        req = 4'b0000;

        // Opcode sweep on requester 0.
        for (int k = 0; k < 4; k++) begin
            set_slot(0, sweep_op[k], 5'b11000, 5'b10010);
            req = 4'b0001;
            step();
            check("sweep_gnt", 8'(gnt), 8'b0001);
            req = 4'b0000;
            step();
            check("sweep_data", 8'(res_data), 8'(sweep_res[k]));
            check("sweep_id", 8'(res_id), 8'd0);
            step();
        end

        // Backpressure: requester 1 (XOR -> 11010) wins after 0 was last served.
        res_ready = 1'b0;
        set_slot(0, 2'b00, 5'b11111, 5'b00110);
        set_slot(1, 2'b10, 5'b10101, 5'b01111);
        req = 4'b0011;
        step();
        check("bp_gnt", 8'(gnt), 8'b0010);
        step();
        check("bp_valid", 8'(res_valid), 8'h01);
        check("bp_data", 8'(res_data), 8'b11010);
        check("bp_id", 8'(res_id), 8'd1);
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp_hold_valid", 8'(res_valid), 8'h01);
            check("bp_hold_data", 8'(res_data), 8'b11010);
            check("bp_hold_id", 8'(res_id), 8'd1);
            check("bp_hold_gnt", 8'(gnt), 8'h00);
        end
        res_ready = 1'b1;
        step();
        check("bp_accept_valid", 8'(res_valid), 8'h00);
        check("bp_accept_busy", 8'(busy), 8'h00);
        step();
        check("bp_next_gnt", 8'(gnt), 8'b0001);
        req = 4'b0000;
        step();
        check("bp_next_data", 8'(res_data), 8'b00110);
        check("bp_next_id", 8'(res_id), 8'd0);
        step();

        // Reset in RESP discards the result and restores requester 0 priority.
        res_ready = 1'b0;
        set_slot(2, 2'b01, 5'b11111, 5'b00000);
        req = 4'b0100;
        step();
        check("mid_gnt", 8'(gnt), 8'b0100);
        req = 4'b0000;
        step();
        check("mid_valid", 8'(res_valid), 8'h01);
        check("mid_data", 8'(res_data), 8'b11111);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 8'(gnt), 8'h00);
        check("mid_rst_valid", 8'(res_valid), 8'h00);
        check("mid_rst_data", 8'(res_data), 8'h00);
        check("mid_rst_id", 8'(res_id), 8'h00);
        check("mid_rst_busy", 8'(busy), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        req = 4'b1111;
        step();
        check("mid_after_gnt", 8'(gnt), 8'b0001);
        req = 4'b0000;
        step();
        step();

        // Wrap-around: serve 3, then 0 beats 3.
        req = 4'b1000;
        step();
        check("wrap_gnt3", 8'(gnt), 8'b1000);
        req = 4'b0000;
        step();
        check("wrap_id3", 8'(res_id), 8'd3);
        step();
        req = 4'b1001;
        step();
        check("wrap_gnt0", 8'(gnt), 8'b0001);
        req = 4'b1000;
        step();
        step();
        step();
        check("wrap_gnt3b", 8'(gnt), 8'b1000);
        req = 4'b0000;
        step();
        step();
        check("final_busy", 8'(busy), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
